// File: rtl/nf10_axis_pkt_loopback_if.sv
// AXI4-Stream bundle used on both sides of the packet loopback buffer.
// master: drives the payload and tvalid, receives tready.
// slave : receives the payload and tvalid, drives tready.
interface nf10_axis_pkt_loopback_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int TUSER_WIDTH = 128
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [TUSER_WIDTH-1:0]  tuser;
    logic                    tvalid;
    logic                    tready;
    logic                    tlast;

    modport master (
        output tdata,
        output tstrb,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tstrb,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/nf10_axis_pkt_loopback.sv
// Store-and-forward AXI4-Stream packet loopback.
// Whole packets are written into a circular buffer and become readable only once
// their tlast beat has been stored (commit pointer). A packet that runs into a
// full buffer is rewound and the rest of it discarded; forwarded and dropped
// packets are counted. The read side is a block-RAM registered read followed by
// a one-entry output register, giving 1 beat/cycle in steady state.
// Optional feature: define NF10_LOOPBACK_ERR_INJECT_EN to add the err_inject port,
// which flips tdata[0] on the first beat of the next outgoing packet.
module nf10_axis_pkt_loopback #(
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_DEPTH_LOG2       = 5
) (
    input  logic                          aclk,
    input  logic                          areset,
    nf10_axis_pkt_loopback_if.slave       s_axis,
    nf10_axis_pkt_loopback_if.master      m_axis,
    output logic [15:0]                   pkt_cnt,
    output logic [15:0]                   drop_cnt
`ifdef NF10_LOOPBACK_ERR_INJECT_EN
    ,
    input  logic                          err_inject
`endif
);

    localparam int STRB_W  = C_AXIS_DATA_WIDTH / 8;
    localparam int ENTRY_W = 1 + C_AXIS_TUSER_WIDTH + STRB_W + C_AXIS_DATA_WIDTH;
    localparam int DEPTH   = 1 << C_DEPTH_LOG2;
    localparam int PTR_W   = C_DEPTH_LOG2 + 1;

    // Occupancy value that means every slot holds a (committed or pending) beat.
    localparam logic [PTR_W-1:0] FULL_OCC = {1'b1, {C_DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2
    } wr_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_state_t                     wr_state_reg;
    logic [PTR_W-1:0]              wr_ptr_reg;
    logic [PTR_W-1:0]              commit_ptr_reg;
    logic [PTR_W-1:0]              rd_ptr_reg;
    logic [15:0]                   pkt_cnt_reg;
    logic [15:0]                   drop_cnt_reg;

    logic [ENTRY_W-1:0]            mem [DEPTH];
    logic [ENTRY_W-1:0]            rd_data_reg;
    logic                          rd_valid_reg;

    logic [C_AXIS_DATA_WIDTH-1:0]  m_tdata_reg;
    logic [STRB_W-1:0]             m_tstrb_reg;
    logic [C_AXIS_TUSER_WIDTH-1:0] m_tuser_reg;
    logic                          m_tlast_reg;
    logic                          m_tvalid_reg;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                          s_beat;
    logic [PTR_W-1:0]              occupancy;
    logic                          full;
    logic                          wr_en;
    logic [PTR_W-1:0]              wr_ptr_inc;
    logic [ENTRY_W-1:0]            wr_entry;
    logic                          rd_avail;
    logic                          rd_en;
    logic                          out_load;
    logic                          stage_adv;
    logic                          m_hs;
    logic                          inj_now;

    logic [C_AXIS_DATA_WIDTH-1:0]  rd_tdata;
    logic [STRB_W-1:0]             rd_tstrb;
    logic [C_AXIS_TUSER_WIDTH-1:0] rd_tuser;
    logic                          rd_tlast;

    // The source is never back-pressured; overflow is handled by dropping.
    assign s_axis.tready = 1'b1;

    // Ingress bookkeeping: full is judged on pointer values before the edge,
    // so a read in the same cycle does not make room for this beat.
    always_comb begin
        s_beat     = s_axis.tvalid;
        occupancy  = wr_ptr_reg - rd_ptr_reg;
        full       = (occupancy == FULL_OCC);
        wr_en      = s_beat && !full && (wr_state_reg != ST_DROP);
        wr_ptr_inc = wr_ptr_reg + PTR_W'(1);
        wr_entry   = {s_axis.tlast, s_axis.tuser, s_axis.tstrb, s_axis.tdata};
    end

    // Egress pipeline control: RAM read stage feeds the output register.
    always_comb begin
        rd_avail  = (rd_ptr_reg != commit_ptr_reg);
        out_load  = !m_tvalid_reg || m_axis.tready;
        stage_adv = rd_valid_reg && out_load;
        rd_en     = rd_avail && (!rd_valid_reg || out_load);
        m_hs      = m_tvalid_reg && m_axis.tready;
    end

    // Split the stored entry back into its fields.
    always_comb begin
        rd_tdata = rd_data_reg[C_AXIS_DATA_WIDTH-1:0];
        rd_tstrb = rd_data_reg[C_AXIS_DATA_WIDTH +: STRB_W];
        rd_tuser = rd_data_reg[C_AXIS_DATA_WIDTH + STRB_W +: C_AXIS_TUSER_WIDTH];
        rd_tlast = rd_data_reg[ENTRY_W-1];
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ------------------------------------------------------------------
    // Write FSM: stores beats, commits on tlast, rewinds and drops on overflow.
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_state_reg   <= ST_IDLE;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            case (wr_state_reg)
                ST_IDLE: begin
                    if (s_beat) begin
                        if (!full) begin
                            wr_ptr_reg <= wr_ptr_inc;
                            if (s_axis.tlast) begin
                                commit_ptr_reg <= wr_ptr_inc;
                            end else begin
                                wr_state_reg <= ST_WRITE;
                            end
                        end else if (s_axis.tlast) begin
                            drop_cnt_reg <= sat_inc(drop_cnt_reg);
                        end else begin
                            wr_state_reg <= ST_DROP;
                        end
                    end
                end
                ST_WRITE: begin
                    if (s_beat) begin
                        if (!full) begin
                            wr_ptr_reg <= wr_ptr_inc;
                            if (s_axis.tlast) begin
                                commit_ptr_reg <= wr_ptr_inc;
                                wr_state_reg   <= ST_IDLE;
                            end
                        end else begin
                            // Discard the partial packet already in the buffer.
                            wr_ptr_reg <= commit_ptr_reg;
                            if (s_axis.tlast) begin
                                drop_cnt_reg <= sat_inc(drop_cnt_reg);
                                wr_state_reg <= ST_IDLE;
                            end else begin
                                wr_state_reg <= ST_DROP;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (s_beat && s_axis.tlast) begin
                        drop_cnt_reg <= sat_inc(drop_cnt_reg);
                        wr_state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    wr_state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Packet buffer: synchronous write, registered read (block RAM).
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[C_DEPTH_LOG2-1:0]] <= wr_entry;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_ptr_reg[C_DEPTH_LOG2-1:0]];
        end
    end

    // Read pointer and RAM-output valid flag.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_ptr_reg   <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
                rd_valid_reg <= 1'b1;
            end else if (stage_adv) begin
                rd_valid_reg <= 1'b0;
            end
        end
    end

`ifdef NF10_LOOPBACK_ERR_INJECT_EN
    logic inj_armed_reg;
    logic out_sop_reg;

    // Fire only when a first-of-packet beat moves into the output register.
    assign inj_now = inj_armed_reg && out_sop_reg && stage_adv;

    // One-shot arm flag plus start-of-packet tracker for the egress stream.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            inj_armed_reg <= 1'b0;
            out_sop_reg   <= 1'b1;
        end else begin
            inj_armed_reg <= (inj_armed_reg && !inj_now) || err_inject;
            if (stage_adv) begin
                out_sop_reg <= rd_tlast;
            end
        end
    end
`else
    assign inj_now = 1'b0;
`endif

    // Output register: refills when empty or when the current beat is taken,
    // otherwise holds every m_axis field stable.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_tvalid_reg <= 1'b0;
            m_tlast_reg  <= 1'b0;
            m_tdata_reg  <= '0;
            m_tstrb_reg  <= '0;
            m_tuser_reg  <= '0;
        end else if (out_load) begin
            m_tvalid_reg <= rd_valid_reg;
            if (rd_valid_reg) begin
                m_tlast_reg <= rd_tlast;
                m_tdata_reg <= rd_tdata ^ {{(C_AXIS_DATA_WIDTH-1){1'b0}}, inj_now};
                m_tstrb_reg <= rd_tstrb;
                m_tuser_reg <= rd_tuser;
            end
        end
    end

    // Forwarded-packet counter, wraps naturally.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pkt_cnt_reg <= '0;
        end else if (m_hs && m_tlast_reg) begin
            pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
        end
    end

    assign m_axis.tvalid = m_tvalid_reg;
    assign m_axis.tlast  = m_tlast_reg;
    assign m_axis.tdata  = m_tdata_reg;
    assign m_axis.tstrb  = m_tstrb_reg;
    assign m_axis.tuser  = m_tuser_reg;
    assign pkt_cnt       = pkt_cnt_reg;
    assign drop_cnt      = drop_cnt_reg;

endmodule
